// File: rtl/hist_peak_reader.sv
// Histogram RAM read side: scans each pixel's bins, clears every bin after reading it,
// and streams one peak record per pixel over a valid/ready handshake.
module hist_peak_reader #(
  parameter int unsigned NB      = 5,
  parameter int unsigned CW      = 8,
  parameter int unsigned PIXELS  = 200,
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned MIN_CNT = 2
) (
  input  logic                clk,
  input  logic                res,
  input  logic                start,
  input  logic                his_sel,
  output logic                rd_en,
  output logic                rd_bank,
  output logic [PIX_W+NB-1:0] rd_addr,
  input  logic [CW-1:0]       rd_data,
  output logic                clr_en,
  output logic [PIX_W+NB-1:0] clr_addr,
  output logic                pk_valid,
  input  logic                pk_ready,
  output logic [PIX_W-1:0]    pk_pixel,
  output logic [NB-1:0]       pk_bin,
  output logic [CW-1:0]       pk_count,
  output logic                pk_hit,
  output logic                busy,
  output logic                done,
  output logic                overrun
);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, EMIT, FIN} state_t;

  localparam logic [NB-1:0]    BIN_ONE  = 1;
  localparam logic [PIX_W-1:0] PIX_ONE  = 1;
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIXELS - 1);
  localparam logic [CW-1:0]    MIN_C    = CW'(MIN_CNT);

  state_t           state;
  logic [NB-1:0]    bin;
  logic [PIX_W-1:0] pixel;
  logic [NB-1:0]    max_bin;
  logic [CW-1:0]    max_cnt;
  logic [NB-1:0]    bin_nxt;
  logic [PIX_W-1:0] pixel_nxt;
  logic [NB-1:0]    cmp_bin;
  logic             take;

  // Compare stage runs one cycle behind the read: clr_en/clr_addr are the delayed read
  // strobe/address, so they mark exactly the cycle in which rd_data is valid.
  always_comb begin
    bin_nxt   = bin + BIN_ONE;
    pixel_nxt = pixel + PIX_ONE;
    cmp_bin   = clr_addr[NB-1:0];
    take      = clr_en && ((cmp_bin == '0) || (rd_data > max_cnt));
  end

  assign pk_pixel = pixel;
  assign pk_bin   = max_bin;
  assign pk_count = max_cnt;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state    <= IDLE;
      bin      <= '0;
      pixel    <= '0;
      max_bin  <= '0;
      max_cnt  <= '0;
      rd_en    <= 1'b0;
      rd_bank  <= 1'b0;
      rd_addr  <= '0;
      clr_en   <= 1'b0;
      clr_addr <= '0;
      pk_valid <= 1'b0;
      pk_hit   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      done     <= 1'b0;
      clr_en   <= rd_en;
      clr_addr <= rd_addr;
      if (take) begin
        max_cnt <= rd_data;
        max_bin <= cmp_bin;
        pk_hit  <= (rd_data >= MIN_C);
      end
      if (start && (state != IDLE)) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            rd_bank <= his_sel;
            pixel   <= '0;
            bin     <= '0;
            rd_addr <= '0;
            rd_en   <= 1'b1;
            overrun <= 1'b0;
            busy    <= 1'b1;
            state   <= READ;
          end
        end
        READ: begin
          if (bin == '1) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else begin
            bin     <= bin_nxt;
            rd_addr <= {pixel, bin_nxt};
          end
        end
        DRAIN: begin
          pk_valid <= 1'b1;
          state    <= EMIT;
        end
        EMIT: begin
          if (pk_ready) begin
            pk_valid <= 1'b0;
            if (pixel == LAST_PIX) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              pixel   <= pixel_nxt;
              bin     <= '0;
              rd_addr <= {pixel_nxt, {NB{1'b0}}};
              rd_en   <= 1'b1;
              state   <= READ;
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hist_peak_reader.sv
// Bench for hist_peak_reader: behavioural two-bank histogram RAM, table of corner-case
// pixels, and a scoreboard of expected peak records consumed on each handshake.
module tb_hist_peak_reader;

  localparam int BINS   = 32;
  localparam int PIXELS = 200;
  localparam int WORDS  = PIXELS * BINS;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        start = 1'b0;
  logic        his_sel = 1'b0;
  logic        pk_ready = 1'b0;
  logic        rd_en, rd_bank, clr_en, pk_valid, pk_hit, busy, done, overrun;
  logic [12:0] rd_addr, clr_addr;
  logic [7:0]  rd_data;
  logic [7:0]  pk_pixel, pk_count;
  logic [4:0]  pk_bin;

  hist_peak_reader #(.NB(5), .CW(8), .PIXELS(200), .PIX_W(8), .MIN_CNT(2)) dut (
    .clk(clk), .res(res), .start(start), .his_sel(his_sel),
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_data(rd_data),
    .clr_en(clr_en), .clr_addr(clr_addr),
    .pk_valid(pk_valid), .pk_ready(pk_ready), .pk_pixel(pk_pixel), .pk_bin(pk_bin),
    .pk_count(pk_count), .pk_hit(pk_hit), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Histogram RAM: registered read, write-zero port, and a bench-side load port.
  logic [7:0]  mem     [2][WORDS];
  int          clr_cnt [2][WORDS];
  logic        wr_en = 1'b0;
  logic        wr_bank = 1'b0;
  logic [12:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_bank][rd_addr];
    if (clr_en) begin
      mem[rd_bank][clr_addr]     <= '0;
      clr_cnt[rd_bank][clr_addr] <= clr_cnt[rd_bank][clr_addr] + 1;
    end
    if (wr_en) mem[wr_bank][wr_addr] <= wr_data;
  end

  logic [63:0] all_outs;
  logic [31:0] out_rec;
  assign all_outs = {9'b0, rd_en, rd_bank, rd_addr, clr_en, clr_addr, pk_valid, pk_pixel,
                     pk_bin, pk_count, pk_hit, busy, done, overrun};
  assign out_rec  = {9'b0, pk_valid, pk_pixel, pk_bin, pk_count, pk_hit};

  typedef struct {
    int pix; int base; int b1; int v1; int b2; int v2; int eb; int ec; bit eh;
  } vec_t;

  vec_t        vt [10];
  int          tab_idx [PIXELS];
  logic [7:0]  img [2][WORDS];
  logic [31:0] sb [$];

  int n_chk = 0, n_fail = 0;
  int rec_cnt, done_cnt, done_at, bank_err, emit_err, stab_err;
  int hold_left, hold_ok, hold_pix;
  bit held, ready_rand, prev_v, prev_acc;
  logic [31:0] prev_rec, hold_rec;
  logic        exp_bank;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_rec(input int bank, input int p);
    int best = 0;
    int bb = 0;
    for (int b = 0; b < BINS; b++) begin
      if (b == 0 || int'(img[bank][p*BINS+b]) > best) begin
        best = int'(img[bank][p*BINS+b]);
        bb   = b;
      end
    end
    return {9'b0, 1'b1, 8'(p), 5'(bb), 8'(best), best >= 2};
  endfunction

  task automatic reset_counters();
    rec_cnt = 0; done_cnt = 0; done_at = -1; bank_err = 0; emit_err = 0; stab_err = 0;
    prev_v = 1'b0; prev_acc = 1'b0; prev_rec = '0;
  endtask

  // Monitor, sampled on the falling edge.
  task automatic sample();
    if (!res) begin
      prev_v = 1'b0;
      return;
    end
    if (rd_en && rd_bank !== exp_bank) bank_err++;
    if (pk_valid && (rd_en || clr_en)) emit_err++;
    if (prev_v && !prev_acc && out_rec !== prev_rec) stab_err++;
    if (hold_left > 0 && pk_valid && !rd_en && !clr_en && out_rec === hold_rec) hold_ok++;
    if (done) begin
      done_cnt++;
      done_at = rec_cnt;
    end
    if (pk_valid && pk_ready) begin
      rec_cnt++;
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) check("record", 64'(out_rec), 64'(sb.pop_front()));
    end
    prev_v   = pk_valid;
    prev_acc = pk_valid && pk_ready;
    prev_rec = out_rec;
  endtask

  // One clock: sample at negedge, then drive pk_ready just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    if (hold_left > 0) begin
      hold_left--;
      pk_ready = (hold_left == 0);
    end else if (!held && pk_valid && int'(pk_pixel) == hold_pix) begin
      held      = 1'b1;
      hold_left = 10;
      hold_rec  = out_rec;
      pk_ready  = 1'b0;
    end else begin
      pk_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  initial begin
    int n, bad;
    vt[0] = '{0,   1,  7,   9,  7,   9,  7,   9, 1'b1};
    vt[1] = '{1,   0,  3,   5, 12,   5,  3,   5, 1'b1};
    vt[2] = '{2,   0,  0,   0,  0,   0,  0,   0, 1'b0};
    vt[3] = '{3,   4, 31, 255, 31, 255, 31, 255, 1'b1};
    vt[4] = '{4,   0,  9,   1,  9,   1,  9,   1, 1'b0};
    vt[5] = '{5,   0, 20,   2, 20,   2, 20,   2, 1'b1};
    vt[6] = '{6,   7,  0,   7,  0,   7,  0,   7, 1'b1};
    vt[7] = '{199, 3,  0,   8, 31,   8,  0,   8, 1'b1};
    vt[8] = '{100,10, 15, 200, 16, 201, 16, 201, 1'b1};
    vt[9] = '{7,   2, 31,   3, 30,   3, 30,   3, 1'b1};

    hold_left = 0; hold_ok = 0; hold_pix = 3; held = 1'b0; ready_rand = 1'b1;
    exp_bank = 1'b1; hold_rec = '0;
    reset_counters();

    repeat (3) cycle();
    check("reset_outputs", all_outs, 64'd0);
    res = 1'b1;

    for (int p = 0; p < PIXELS; p++) tab_idx[p] = -1;
    for (int bk = 0; bk < 2; bk++)
      for (int a = 0; a < WORDS; a++) img[bk][a] = 8'($urandom_range(0, 40));
    for (int i = 0; i < 10; i++) begin
      tab_idx[vt[i].pix] = i;
      for (int b = 0; b < BINS; b++) img[1][vt[i].pix*BINS+b] = 8'(vt[i].base);
      img[1][vt[i].pix*BINS+vt[i].b1] = 8'(vt[i].v1);
      img[1][vt[i].pix*BINS+vt[i].b2] = 8'(vt[i].v2);
    end
    for (int bk = 0; bk < 2; bk++)
      for (int a = 0; a < WORDS; a++) begin
        wr_en = 1'b1; wr_bank = bk[0]; wr_addr = 13'(a); wr_data = img[bk][a];
        cycle();
      end
    wr_en = 1'b0;

    // Full frame on bank 1 with random backpressure and a 10-cycle stall on pixel 3.
    for (int p = 0; p < PIXELS; p++) begin
      if (tab_idx[p] >= 0)
        sb.push_back({9'b0, 1'b1, 8'(p), 5'(vt[tab_idx[p]].eb), 8'(vt[tab_idx[p]].ec),
                      vt[tab_idx[p]].eh});
      else
        sb.push_back(ref_rec(1, p));
    end
    reset_counters();
    his_sel = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0; his_sel = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_overrun_clear", 64'(overrun), 64'd0);
    repeat (60) cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    check("overrun_set", 64'(overrun), 64'd1);
    n = 0;
    while (busy && n < 30000) begin
      cycle();
      n++;
    end
    check("frameA_finished", 64'(busy), 64'd0);
    check("frameA_records", 64'(rec_cnt), 64'd200);
    check("frameA_sb_empty", 64'(sb.size()), 64'd0);
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("done_after_last", 64'(done_at), 64'd200);
    check("rd_bank_const", 64'(bank_err), 64'd0);
    check("no_io_in_emit", 64'(emit_err), 64'd0);
    check("valid_stable", 64'(stab_err), 64'd0);
    check("stall_seen", 64'(held), 64'd1);
    check("stall_hold_cycles", 64'(hold_ok), 64'd10);
    check("overrun_sticky", 64'(overrun), 64'd1);
    bad = 0;
    for (int a = 0; a < WORDS; a++) begin
      if (clr_cnt[1][a] != 1 || mem[1][a] != 8'd0) bad++;
      if (clr_cnt[0][a] != 0 || mem[0][a] !== img[0][a]) bad++;
    end
    check("bins_cleared_once", 64'(bad), 64'd0);

    // Bank 0 frame aborted by reset during pixel 1's read phase.
    ready_rand = 1'b0;
    exp_bank = 1'b0;
    for (int p = 0; p < PIXELS; p++) sb.push_back(ref_rec(0, p));
    reset_counters();
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("restart_overrun_clear", 64'(overrun), 64'd0);
    repeat (39) cycle();
    check("midscan_reading", {63'b0, rd_en}, 64'd1);
    check("midscan_pixel", 64'(rd_addr[12:5]), 64'd1);
    res = 1'b0;
    #1;
    check("async_reset_outputs", all_outs, 64'd0);
    cycle();
    check("reset_hold_outputs", all_outs, 64'd0);
    res = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (rd_en || clr_en || busy || pk_valid) bad++;
    end
    check("idle_after_reset", 64'(bad), 64'd0);
    check("abort_records", 64'(rec_cnt), 64'd1);
    sb.delete();
    bad = 0;
    for (int a = 0; a < BINS; a++) if (mem[0][a] != 8'd0 || clr_cnt[0][a] != 1) bad++;
    check("pixel0_cleared", 64'(bad), 64'd0);
    bad = 0;
    for (int a = 2 * BINS; a < WORDS; a++) if (mem[0][a] !== img[0][a] || clr_cnt[0][a] != 0) bad++;
    check("later_bins_kept", 64'(bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
